cntr_updn_prog: RTL
===================

// Module: cntr_updn_prog
// PURPOSE
//   Runtime-programmable up/down counter: successor to the fixed-limit up/down counter.
//   Adds runtime min/max/step/mode config, synchronous load, one-shot mode with DONE state,
//   terminal-count pulse and sticky overflow/underflow flags. Used as a timer, pointer
//   or credit counter in control paths.
// PARAMETERS
//   WIDTH    5                  counter/config bit width
//   MIN_CNT  0                  reset value of active min limit (truncated to WIDTH)
//   MAX_CNT  (1<<WIDTH)-1       reset value of active max limit (truncated to WIDTH)
//   STEP     1                  reset value of active step (truncated to WIDTH)
//   MODE     0                  reset mode: 0=clamp 1=wrap 2=one-shot 3=reserved(acts as clamp)
// PORTS
//   i_clk        in   1      clock, all logic on rising edge
//   i_arst_n     in   1      reset, asynchronous, active-low
//   i_en         in   1      count enable, one step per enabled cycle
//   i_updn       in   1      1=up, 0=down
//   i_load       in   1      synchronous load of i_load_val (priority over i_en)
//   i_load_val   in   WIDTH  load value
//   i_cfg_wr     in   1      write i_cfg_* into active config
//   i_cfg_min    in   WIDTH  new min limit
//   i_cfg_max    in   WIDTH  new max limit
//   i_cfg_step   in   WIDTH  new step size
//   i_cfg_mode   in   2      new mode
//   i_clr_flags  in   1      clear o_ovf/o_udf/o_cfg_err
//   o_count      out  WIDTH  current count
//   o_max/o_min  out  1      comb: o_count==max/min; forced 0 while i_arst_n low
//   o_max_pipe   out  1      o_max registered (1-cycle delay, updates on i_en)
//   o_min_pipe   out  1      o_min registered (1-cycle delay, updates on i_en)
//   o_tc         out  1      1-cycle pulse: enabled step hit a limit (wrap, clamp or done)
//   o_ovf/o_udf  out  1      sticky: an up/down step would have exceeded max/below min
//   o_done       out  1      FSM in DONE (one-shot finished)
//   o_cfg_err    out  1      sticky: cfg write rejected
// BEHAVIOUR
// - Reset (async assert, sync release): count=MIN_CNT, config=param defaults, FSM=RUN,
//   all registered outputs 0; pipe flags stay 0 until one enabled cycle after reset.
// - Config: written on i_cfg_wr, effective from next cycle.
//   Rejected (old kept, o_cfg_err set) if min>max or step==0.
//   Accepted write does not move o_count, even if outside new limits.
// - Priority per cycle: i_load > i_en step. i_load: count = i_load_val clamped to
//   [min,max] of the config active that cycle; FSM -> RUN; no o_tc, no ovf/udf.
// - Step arithmetic in WIDTH+1 bits, no silent wrap at 2^WIDTH:
//     up:   hit if count+step > max;  down: hit if count < min+step (unsigned, WIDTH+1)
//   No hit: count +/- step.
//   Hit:    clamp/3: count=max (up) or min (down)
//           wrap:    count=min (up) or max (down), no remainder carried
//           one-shot: count=max/min, FSM RUN->DONE
//   Hit pulses o_tc next cycle and sets o_ovf (up) or o_udf (down).
//   Clamp at limit with further steps: count unchanged, o_tc and flag assert each cycle.
// - FSM RUN/DONE: DONE ignores i_en (count frozen, no o_tc). Exit via i_load,
//   or accepted cfg write with mode!=2 (RUN next cycle).
// - Pipe flags: on i_en cycles, r_max <= valid && count==max (same for min),
//   valid set after first i_en post-reset.
// - Sticky flags: i_clr_flags clears; a set event in the same cycle wins.
// - Reset mid-operation: everything returns to reset values immediately,
//   including pending o_tc.
// TESTING
// 1. W=5 defaults, en up 33 cycles -> count 0..31, clamps at 31, o_tc/o_ovf from cycle 32, o_max=1.
// 2. cfg min=4 max=10 step=3 wrap, load 4, up -> 4,7,10,4(o_tc),7; down from 4 -> 10, o_udf=1.
// 3. one-shot max=9 step=4 from 0 up -> 4,8,9, o_done=1; i_en ignored; i_load 2 -> RUN, count 2.
// 4. cfg min=12 max=3 -> rejected, o_cfg_err=1, old limits still active; i_clr_flags clears it.
// 5. W=8 max=255 step=200 at count 100 up, clamp -> 255 (no 2^8 wrap), o_ovf=1.
// 6. i_arst_n low mid-count with i_load+i_en high -> count=MIN_CNT, all flags 0, o_min=0 during reset.

Source files
------------

// File: rtl/cntr_updn_prog.sv
// -----------------------------------------------------------------------------
// cntr_updn_prog
//   Runtime-programmable up/down counter for timer, pointer and credit use in
//   control paths. The active limits (min/max), step size and mode are held in
//   a config register that software rewrites at runtime. Modes:
//     0 clamp    : a step past a limit parks the count on that limit
//     1 wrap     : a step past a limit restarts at the opposite limit
//     2 one-shot : like clamp, but the FSM then enters DONE and ignores i_en
//     3 reserved : behaves as clamp
//   A synchronous load has priority over stepping and always returns the FSM
//   to RUN. Step arithmetic is done one bit wider than the count, so a large
//   step never silently wraps at 2^WIDTH.
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_arst_n     asynchronous active-low reset
//   i_en         count enable, one step per enabled cycle
//   i_updn       step direction, 1 = up, 0 = down
//   i_load       load i_load_val (clamped to the active limits)
//   i_load_val   load value
//   i_cfg_wr     write i_cfg_min/max/step/mode into the active config
//   i_cfg_min    new min limit
//   i_cfg_max    new max limit
//   i_cfg_step   new step size
//   i_cfg_mode   new mode
//   i_clr_flags  clear o_ovf, o_udf and o_cfg_err
//   o_count      current count
//   o_max        combinational: o_count == active max (0 while in reset)
//   o_min        combinational: o_count == active min (0 while in reset)
//   o_max_pipe   o_max registered on enabled cycles
//   o_min_pipe   o_min registered on enabled cycles
//   o_tc         one-cycle pulse after an enabled step hit a limit
//   o_ovf        sticky: an up step would have passed max
//   o_udf        sticky: a down step would have passed min
//   o_done       FSM is in DONE (one-shot finished)
//   o_cfg_err    sticky: a config write was rejected
// -----------------------------------------------------------------------------
module cntr_updn_prog #(
  parameter int WIDTH   = 5,
  parameter int MIN_CNT = 0,
  parameter int MAX_CNT = (1 << WIDTH) - 1,
  parameter int STEP    = 1,
  parameter int MODE    = 0
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_en,
  input  logic             i_updn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_cfg_wr,
  input  logic [WIDTH-1:0] i_cfg_min,
  input  logic [WIDTH-1:0] i_cfg_max,
  input  logic [WIDTH-1:0] i_cfg_step,
  input  logic [1:0]       i_cfg_mode,
  input  logic             i_clr_flags,
  output logic [WIDTH-1:0] o_count,
  output logic             o_max,
  output logic             o_min,
  output logic             o_max_pipe,
  output logic             o_min_pipe,
  output logic             o_tc,
  output logic             o_ovf,
  output logic             o_udf,
  output logic             o_done,
  output logic             o_cfg_err
);

  localparam logic [WIDTH-1:0] MIN_RST  = WIDTH'(MIN_CNT);
  localparam logic [WIDTH-1:0] MAX_RST  = WIDTH'(MAX_CNT);
  localparam logic [WIDTH-1:0] STEP_RST = WIDTH'(STEP);
  localparam logic [1:0]       MODE_RST = 2'(MODE);

  localparam logic [1:0] MODE_WRAP    = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  // Active configuration
  logic [WIDTH-1:0] cfg_min;
  logic [WIDTH-1:0] cfg_max;
  logic [WIDTH-1:0] cfg_step;
  logic [1:0]       cfg_mode;

  // Counter state
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [0:0]       state;
  logic [0:0]       state_next;

  // Registered flags
  logic             tc;
  logic             ovf;
  logic             udf;
  logic             cfg_err;
  logic             max_p1;
  logic             min_p1;
  logic             vld_p1;

  // Step evaluation
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_floor;
  logic             up_hit;
  logic             dn_hit;
  logic             step_go;
  logic             hit;
  logic             cfg_ok;
  logic             cfg_bad;

  // Saturate a load value into the active window.
  function automatic logic [WIDTH-1:0] clamp_range(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi
  );
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Landing value when a step crosses a limit: wrap mode restarts at the
  // opposite limit (no remainder carried), every other mode parks on the
  // limit that was crossed.
  function automatic logic [WIDTH-1:0] limit_on_hit(
    input logic [1:0]       mode,
    input logic             up,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi
  );
    if (mode == MODE_WRAP) return up ? lo : hi;
    else                   return up ? hi : lo;
  endfunction

  // Widened compares: count+step cannot overflow, and min+step cannot either,
  // so "count - step < min" is tested as "count < min + step" without
  // an unsigned borrow.
  assign up_sum   = {1'b0, count} + {1'b0, cfg_step};
  assign dn_floor = {1'b0, cfg_min} + {1'b0, cfg_step};
  assign up_hit   = up_sum > {1'b0, cfg_max};
  assign dn_hit   = {1'b0, count} < dn_floor;

  assign step_go  = i_en && !i_load && (state == ST_RUN);
  assign hit      = step_go && (i_updn ? up_hit : dn_hit);

  assign cfg_bad  = i_cfg_wr && ((i_cfg_min > i_cfg_max) || (i_cfg_step == '0));
  assign cfg_ok   = i_cfg_wr && !cfg_bad;

  always_comb begin
    count_next = count;
    if (i_load) begin
      count_next = clamp_range(i_load_val, cfg_min, cfg_max);
    end else if (step_go) begin
      if (i_updn) begin
        count_next = up_hit ? limit_on_hit(cfg_mode, 1'b1, cfg_min, cfg_max)
                            : up_sum[WIDTH-1:0];
      end else begin
        count_next = dn_hit ? limit_on_hit(cfg_mode, 1'b0, cfg_min, cfg_max)
                            : count - cfg_step;
      end
    end
  end

  // Later assignments take precedence: a load always restarts, an accepted
  // non-one-shot config releases DONE, otherwise a one-shot hit enters DONE.
  always_comb begin
    state_next = state;
    if (hit && (cfg_mode == MODE_ONESHOT)) state_next = ST_DONE;
    if (cfg_ok && (i_cfg_mode != MODE_ONESHOT)) state_next = ST_RUN;
    if (i_load) state_next = ST_RUN;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cfg_min  <= MIN_RST;
      cfg_max  <= MAX_RST;
      cfg_step <= STEP_RST;
      cfg_mode <= MODE_RST;
    end else if (cfg_ok) begin
      cfg_min  <= i_cfg_min;
      cfg_max  <= i_cfg_max;
      cfg_step <= i_cfg_step;
      cfg_mode <= i_cfg_mode;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      count <= MIN_RST;
      state <= ST_RUN;
    end else begin
      count <= count_next;
      state <= state_next;
    end
  end

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tc      <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      tc      <= hit;
      ovf     <= (ovf & ~i_clr_flags) | (hit & i_updn);
      udf     <= (udf & ~i_clr_flags) | (hit & ~i_updn);
      cfg_err <= (cfg_err & ~i_clr_flags) | cfg_bad;
    end
  end

  // Stage p1: limit flags sampled on enabled cycles; the first enabled cycle
  // after reset only arms vld_p1, so the pipe flags stay 0 until then.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      max_p1 <= 1'b0;
      min_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (i_en) begin
      max_p1 <= vld_p1 && (count == cfg_max);
      min_p1 <= vld_p1 && (count == cfg_min);
      vld_p1 <= 1'b1;
    end
  end

  assign o_count    = count;
  assign o_max      = i_arst_n && (count == cfg_max);
  assign o_min      = i_arst_n && (count == cfg_min);
  assign o_max_pipe = max_p1;
  assign o_min_pipe = min_p1;
  assign o_tc       = tc;
  assign o_ovf      = ovf;
  assign o_udf      = udf;
  assign o_done     = (state == ST_DONE);
  assign o_cfg_err  = cfg_err;

endmodule
